mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter for the core. It shares one external memory port between the instruction-fetch requester (I) and the load/store requester (D). D has fixed priority, and a starvation counter guarantees fetch forward progress. A fetch response is discarded when the control unit flushes the fetch after a taken branch. The arbiter sits inside the datapath, between the fetch/memory stages and the memory interface, and completes exactly one transaction at a time.

## Interface
- STARVE_LIMIT, 4: consecutive I-loses-to-D arbitrations after which I wins the next contested arbitration.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- i_req_i  in  1  fetch request; held until i_gnt_o.
- i_addr_i  in  32  fetch address.
- i_gnt_o  out  1  fetch request accepted this cycle.
- i_rvalid_o  out  1  fetch data valid.
- i_rdata_o  out  32  fetch data.
- flush_i  in  1  cancel the granted, outstanding fetch (taken branch).
- d_req_i  in  1  load/store request; held until d_gnt_o.
- d_we_i  in  1  1 = store.
- d_be_i  in  4  byte enables.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid, or store complete; this drives memory_done.
- d_rdata_o  out  32  load data.
- m_req_o  out  1  memory request; held until m_ack_i.
- m_we_o  out  1  memory write enable.
- m_be_o  out  4  memory byte enables.
- m_addr_o  out  32  memory address.
- m_wdata_o  out  32  memory write data.
- m_ack_i  in  1  memory accepted the request.
- m_rvalid_i  in  1  response; asserted for both reads and writes, at least 1 cycle after ack.
- m_rdata_i  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: the arbitration decision is combinational on the request inputs.
  - Both requests high: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - Winner gets its gnt high this cycle. Address, data, we and be are registered (I: we=0, be=4'hF).
  - owner register records I or D. Next state is REQ.
- REQ: m_req_o = 1 with the registered fields stable. On m_ack_i, go to WAIT.
- WAIT: on m_rvalid_i, route the response to owner and go to IDLE.
  - Owner D: d_rvalid_o = 1, d_rdata_o = m_rdata_i.
  - Owner I: i_rvalid_o = 1 and i_rdata_o = m_rdata_i, unless drop is set.
- starve_cnt: 0 to STARVE_LIMIT, saturating.
  - Increments when D wins while i_req_i is high.
  - Clears when I is granted.
- drop flag:
  - Set by flush_i while owner = I in REQ or WAIT.
  - A flush_i in the same cycle as the response also suppresses it.
  - Cleared on the return to IDLE.
  - flush_i has no effect in IDLE or when owner = D.
  - m_req_o is never withdrawn: the transaction completes and only the data is dropped.
- The gnt outputs are 0 outside IDLE. No request is accepted while a transaction is outstanding.
- Passthrough to memory outputs is forbidden: all m_* outputs come from registers.

## Timing
- Reset values: state IDLE, owner I, drop 0, starve_cnt 0.
- Every output is 0 during and after reset until a grant, including m_* and the rdata outputs.
- rdata outputs are 0 whenever their rvalid is 0.
- Reset mid-transaction: abort to IDLE immediately. The memory is reset by the same rst.
- Minimum latency:
  - gnt in cycle t.
  - m_req_o in cycle t+1; ack at earliest t+1.
  - m_rvalid_i and the owner's rvalid at earliest t+2 (the rvalid outputs are combinational from m_rvalid_i).
  - Next grant at earliest t+3.
- m_rvalid_i outside WAIT is ignored.
- m_ack_i outside REQ is ignored.

## Structure
- Shared defines header gains:
  - ARB_STATE_WIDTH (2) and the IDLE/REQ/WAIT encodings;
  - OWNER_I and OWNER_D.
- These sit next to the existing SEL_PC_WIDTH definitions.
- One sub-module, arb_prio: pure combinational priority pick with inputs i_req, d_req and starve_hit.
- FSM, registers, starve_cnt and drop logic stay in mem_arbiter.
- Instantiate mem_arbiter inside datapath. d_rvalid_o feeds memory_done; flush_i is driven from br_taken.

## Test plan
- Fetch only:
  - Stimulus: i_req_i=1 with addr 0x100; memory acks in 1 cycle and returns 0xDEADBEEF 2 cycles later.
  - Expected: i_gnt_o in cycle 0, m_req_o/m_addr_o=0x100 in cycle 1, i_rvalid_o with 0xDEADBEEF in cycle 3, IDLE in cycle 4.
- Store:
  - Stimulus: d_req_i with we=1, be=4'b0011, addr 0x200, wdata 0x1234.
  - Expected: m_we_o=1, m_be_o=0011, m_wdata_o=0x1234; d_rvalid_o pulses once on the write response; i_rvalid_o stays 0.
- Contention and starvation:
  - Stimulus: both i_req_i and d_req_i held high continuously, STARVE_LIMIT=4.
  - Expected grant order: D, D, D, D, I, D, D, D, D, I.
- Flush:
  - Stimulus: assert flush_i in WAIT for a fetch.
  - Expected: the memory transaction completes and i_rvalid_o stays 0. The same holds when flush_i coincides with m_rvalid_i.
  - A flush during a D transaction leaves d_rvalid_o unaffected.
- Stalled memory:
  - Stimulus: m_ack_i held low for 5 cycles.
  - Expected: m_req_o and the m_* fields stay stable, and the gnt outputs stay 0 despite new requests.
- Async reset:
  - Stimulus: rst asserted mid-cycle during WAIT.
  - Expected: all outputs 0 without waiting for a clock edge; the first post-reset request is granted normally and starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter.
// Imported by the arbiter top and its priority picker.
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    localparam logic [ARB_STATE_WIDTH-1:0] ARB_IDLE = 2'd0;
    localparam logic [ARB_STATE_WIDTH-1:0] ARB_REQ  = 2'd1;
    localparam logic [ARB_STATE_WIDTH-1:0] ARB_WAIT = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Combinational priority pick between fetch and load/store.
// D wins a contested pick unless fetch has been starved.
module arb_prio (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic i_win,
    output logic d_win
);

    // Fetch wins when alone or when its starvation limit is reached.
    always_comb begin
        i_win = i_req & (~d_req | starve_hit);
        d_win = d_req & ~(i_req & starve_hit);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch (I) vs load/store (D).
// One transaction outstanding; fetch responses droppable by flush.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    input  logic        flush_i,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_ack_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [ARB_STATE_WIDTH-1:0] state;
    logic                       owner;
    logic                       drop;
    logic [CW-1:0]              starve_cnt;
    logic                       starve_hit;
    logic                       i_win;
    logic                       d_win;
    logic                       idle;
    logic                       rsp;
    logic                       grant;

    assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));

    arb_prio u_prio (
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .starve_hit (starve_hit),
        .i_win      (i_win),
        .d_win      (d_win)
    );

    // Grants and response routing; nothing leaks out while in reset.
    always_comb begin
        idle       = (state == ARB_IDLE) && !rst;
        i_gnt_o    = idle & i_win;
        d_gnt_o    = idle & d_win;
        grant      = i_gnt_o | d_gnt_o;
        rsp        = (state == ARB_WAIT) && m_rvalid_i;
        d_rvalid_o = rsp && (owner == OWNER_D);
        i_rvalid_o = rsp && (owner == OWNER_I) && !drop && !flush_i;
        d_rdata_o  = d_rvalid_o ? m_rdata_i : 32'h0;
        i_rdata_o  = i_rvalid_o ? m_rdata_i : 32'h0;
    end

    // Transaction FSM: IDLE -> REQ (until ack) -> WAIT (until response).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: if (grant)      state <= ARB_REQ;
                ARB_REQ:  if (m_ack_i)    state <= ARB_WAIT;
                ARB_WAIT: if (m_rvalid_i) state <= ARB_IDLE;
                default:                  state <= ARB_IDLE;
            endcase
        end
    end

    // Memory-side request registers, captured at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_be_o    <= 4'h0;
            m_addr_o  <= 32'h0;
            m_wdata_o <= 32'h0;
            owner     <= OWNER_I;
        end else if (d_gnt_o) begin
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_be_o    <= d_be_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            owner     <= OWNER_D;
        end else if (i_gnt_o) begin
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_be_o    <= 4'hF;
            m_addr_o  <= i_addr_i;
            m_wdata_o <= 32'h0;
            owner     <= OWNER_I;
        end else if ((state == ARB_REQ) && m_ack_i) begin
            m_req_o   <= 1'b0;
        end
    end

    // Drop flag: remembers a flush against the outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (rsp) begin
            drop <= 1'b0;
        end else if ((state != ARB_IDLE) && (owner == OWNER_I) && flush_i) begin
            drop <= 1'b1;
        end
    end

    // Saturating count of contested arbitrations lost by fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_gnt_o) begin
            starve_cnt <= '0;
        end else if (d_gnt_o && i_req_i && !starve_hit) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus
// hand-written contention, stall and async-reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        flush_i;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_ack_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_gnt_o    (i_gnt_o),
        .i_rvalid_o (i_rvalid_o),
        .i_rdata_o  (i_rdata_o),
        .flush_i    (flush_i),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_be_i     (d_be_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ack_i    (m_ack_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          rsp_dly;
        int          flush_mode;
        bit          exp_irv;
        bit          exp_drv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " i_gnt"},  {31'b0, i_gnt_o},    32'h0);
        chk({tag, " d_gnt"},  {31'b0, d_gnt_o},    32'h0);
        chk({tag, " i_rv"},   {31'b0, i_rvalid_o}, 32'h0);
        chk({tag, " d_rv"},   {31'b0, d_rvalid_o}, 32'h0);
        chk({tag, " i_rd"},   i_rdata_o,           32'h0);
        chk({tag, " d_rd"},   d_rdata_o,           32'h0);
        chk({tag, " m_req"},  {31'b0, m_req_o},    32'h0);
        chk({tag, " m_we"},   {31'b0, m_we_o},     32'h0);
        chk({tag, " m_be"},   {28'b0, m_be_o},     32'h0);
        chk({tag, " m_addr"}, m_addr_o,            32'h0);
        chk({tag, " m_wd"},   m_wdata_o,           32'h0);
    endtask

    task automatic run_vec(int idx, vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        // grant cycle
        @(negedge clk);
        i_req_i   = !v.is_d;
        i_addr_i  = v.addr;
        d_req_i   = v.is_d;
        d_we_i    = v.we;
        d_be_i    = v.be;
        d_addr_i  = v.addr;
        d_wdata_i = v.wdata;
        #1;
        chk({t, " i_gnt"}, {31'b0, i_gnt_o}, {31'b0, !v.is_d});
        chk({t, " d_gnt"}, {31'b0, d_gnt_o}, {31'b0, v.is_d});
        // request phase
        @(negedge clk);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        flush_i = (v.flush_mode == 1);
        for (int k = 0; k <= v.ack_dly; k++) begin
            m_ack_i = (k == v.ack_dly);
            #1;
            chk({t, " m_req"},  {31'b0, m_req_o}, 32'h1);
            chk({t, " m_addr"}, m_addr_o, v.addr);
            chk({t, " m_we"},   {31'b0, m_we_o}, {31'b0, v.is_d & v.we});
            chk({t, " m_be"},   {28'b0, m_be_o},
                {28'b0, v.is_d ? v.be : 4'hF});
            if (v.is_d) chk({t, " m_wd"}, m_wdata_o, v.wdata);
            if (k < v.ack_dly) @(negedge clk);
        end
        // wait phase
        for (int k = 0; k <= v.rsp_dly; k++) begin
            @(negedge clk);
            m_ack_i = 1'b0;
            flush_i = (v.flush_mode == 2 && k == 0) ||
                      (v.flush_mode == 3 && k == v.rsp_dly);
            if (k < v.rsp_dly) begin
                m_rvalid_i = 1'b0;
                #1;
                chk({t, " w m_req"}, {31'b0, m_req_o}, 32'h0);
                chk({t, " w i_rv"}, {31'b0, i_rvalid_o}, 32'h0);
            end else begin
                m_rvalid_i = 1'b1;
                m_rdata_i  = v.rdata;
                #1;
                chk({t, " i_rv"}, {31'b0, i_rvalid_o}, {31'b0, v.exp_irv});
                chk({t, " d_rv"}, {31'b0, d_rvalid_o}, {31'b0, v.exp_drv});
                chk({t, " i_rd"}, i_rdata_o,
                    v.exp_irv ? v.exp_rdata : 32'h0);
                chk({t, " d_rd"}, d_rdata_o,
                    v.exp_drv ? v.exp_rdata : 32'h0);
            end
        end
        // back in idle: response must be a single pulse
        @(negedge clk);
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'h5A5A_5A5A;
        flush_i    = 1'b0;
        #1;
        chk({t, " post i_rv"}, {31'b0, i_rvalid_o}, 32'h0);
        chk({t, " post d_rv"}, {31'b0, d_rvalid_o}, 32'h0);
        chk({t, " post i_rd"}, i_rdata_o, 32'h0);
        chk({t, " post m_req"}, {31'b0, m_req_o}, 32'h0);
    endtask

    // One contested arbitration with both requests held; exp_d = D wins.
    task automatic contend(string t, bit exp_d);
        @(negedge clk);
        m_rvalid_i = 1'b0;
        i_req_i    = 1'b1;
        d_req_i    = 1'b1;
        d_we_i     = 1'b0;
        d_be_i     = 4'hF;
        d_addr_i   = 32'h300;
        i_addr_i   = 32'h400;
        #1;
        chk({t, " i_gnt"}, {31'b0, i_gnt_o}, {31'b0, !exp_d});
        chk({t, " d_gnt"}, {31'b0, d_gnt_o}, {31'b0, exp_d});
        @(negedge clk);
        m_ack_i = 1'b1;
        #1;
        chk({t, " m_addr"}, m_addr_o, exp_d ? 32'h300 : 32'h400);
        @(negedge clk);
        m_ack_i    = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h0000_0777;
        #1;
        chk({t, " d_rv"}, {31'b0, d_rvalid_o}, {31'b0, exp_d});
        chk({t, " i_rv"}, {31'b0, i_rvalid_o}, {31'b0, !exp_d});
    endtask

    bit order[10];

    initial begin
        rst = 1'b1;
        i_req_i = 0; i_addr_i = 0; flush_i = 0;
        d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
        m_ack_i = 0; m_rvalid_i = 0; m_rdata_i = 0;

        //          is_d we be    addr      wdata     rdata         ack rsp fl irv drv exp
        vecs[0] = '{0, 0, 4'hF, 32'h100, 32'h0,    32'hDEADBEEF, 0, 1, 0, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{1, 1, 4'h3, 32'h200, 32'h1234, 32'h0,        0, 0, 0, 0, 1, 32'h0};
        vecs[2] = '{1, 0, 4'hF, 32'h204, 32'h0,    32'hCAFEF00D, 2, 1, 0, 0, 1, 32'hCAFEF00D};
        vecs[3] = '{0, 0, 4'hF, 32'h104, 32'h0,    32'h11111111, 0, 2, 2, 0, 0, 32'h0};
        vecs[4] = '{0, 0, 4'hF, 32'h108, 32'h0,    32'h22222222, 1, 0, 3, 0, 0, 32'h0};
        vecs[5] = '{0, 0, 4'hF, 32'h10C, 32'h0,    32'h33333333, 1, 1, 1, 0, 0, 32'h0};
        vecs[6] = '{1, 0, 4'hF, 32'h208, 32'h0,    32'h44444444, 0, 1, 3, 0, 1, 32'h44444444};
        vecs[7] = '{0, 0, 4'hF, 32'h110, 32'h0,    32'h55555555, 0, 0, 0, 1, 0, 32'h55555555};

        // reset state, with requests already pending
        i_req_i = 1'b1;
        d_req_i = 1'b1;
        m_rvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        m_rvalid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("post-rst");

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // contention: D x4, I, D x4, I
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) contend($sformatf("arb%0d", i), order[i]);
        @(negedge clk);
        m_rvalid_i = 1'b0;
        i_req_i = 1'b0;
        d_req_i = 1'b0;

        // stalled memory: fields stable, no grants
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h6;
        d_addr_i = 32'h500; d_wdata_i = 32'hABCD0123;
        #1;
        chk("stall gnt", {31'b0, d_gnt_o}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req_i = 1'b1; d_req_i = 1'b1;
            d_addr_i = 32'h600; d_wdata_i = 32'h0; d_be_i = 4'h1;
            m_ack_i = 1'b0;
            m_rvalid_i = (k == 2);
            #1;
            chk($sformatf("stall%0d m_req", k), {31'b0, m_req_o}, 32'h1);
            chk($sformatf("stall%0d addr", k), m_addr_o, 32'h500);
            chk($sformatf("stall%0d wd", k), m_wdata_o, 32'hABCD0123);
            chk($sformatf("stall%0d be", k), {28'b0, m_be_o}, 32'h6);
            chk($sformatf("stall%0d gnt", k),
                {30'b0, i_gnt_o, d_gnt_o}, 32'h0);
            chk($sformatf("stall%0d d_rv", k), {31'b0, d_rvalid_o}, 32'h0);
        end
        @(negedge clk);
        m_rvalid_i = 1'b0;
        m_ack_i = 1'b1;
        #1;
        chk("stall ack m_req", {31'b0, m_req_o}, 32'h1);
        @(negedge clk);
        m_ack_i = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i = 32'h0;
        i_req_i = 1'b0; d_req_i = 1'b0;
        #1;
        chk("stall d_rv", {31'b0, d_rvalid_o}, 32'h1);

        // async reset during WAIT with starve count at the limit
        for (int i = 0; i < 3; i++) contend($sformatf("pre%0d", i), 1'b1);
        @(negedge clk);
        m_rvalid_i = 1'b0;
        #1;
        chk("pre3 d_gnt", {31'b0, d_gnt_o}, 32'h1);
        @(negedge clk);
        m_ack_i = 1'b1;
        @(negedge clk);
        m_ack_i = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i = 32'h9999_9999;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async");
        @(negedge clk);
        rst = 1'b0;
        m_rvalid_i = 1'b0;
        #1;
        chk("rst2 d_gnt", {31'b0, d_gnt_o}, 32'h1);
        chk("rst2 i_gnt", {31'b0, i_gnt_o}, 32'h0);
        @(negedge clk);
        i_req_i = 1'b0; d_req_i = 1'b0;
        m_ack_i = 1'b1;
        #1;
        chk("rst2 m_req", {31'b0, m_req_o}, 32'h1);
        @(negedge clk);
        m_ack_i = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i = 32'h0BAD_F00D;
        #1;
        chk("rst2 d_rd", d_rdata_o, 32'h0BAD_F00D);
        @(negedge clk);
        m_rvalid_i = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
